// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - break-before-make sequencer driving a 1-to-4 enabled demux
module demux_route_ctrl #(
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 1,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_dest,
    input  logic       req_data,
    input  logic       abort,
    output logic       d,
    output logic [1:0] s,
    output logic       En,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRIVE,
        ST_GAP
    } state_t;

    localparam int              HOLD_EFF  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam logic [CW-1:0]   HOLD_LD   = CW'(HOLD_EFF - 1);
    // An aborted transfer always spends at least one GAP cycle, so the
    // reload value is the same for the normal and the abort path.
    localparam logic [CW-1:0]   GAP_LD    = CW'((GAP_CYC < 1) ? 0 : GAP_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic            HOLD_ONE  = (HOLD_EFF == 1);
    localparam logic            GAP_NONE  = (GAP_CYC < 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ready;
    logic          r_d;
    logic [1:0]    r_s;
    logic          r_en;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_d       <= 1'b0;
            r_s       <= 2'b00;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // r_ready is low only in the first cycle after reset
                    if (req_valid && r_ready) begin
                        r_s     <= req_dest;
                        r_d     <= req_data;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= HOLD_LD;
                        r_state <= ST_SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_cnt     <= GAP_LD;
                        r_state   <= ST_GAP;
                    end else begin
                        r_en    <= 1'b1;
                        r_done  <= HOLD_ONE;
                        r_cnt   <= HOLD_LD;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        r_en      <= 1'b0;
                        r_aborted <= 1'b1;
                        r_cnt     <= GAP_LD;
                        r_state   <= ST_GAP;
                    end else if (r_cnt == '0) begin
                        r_en <= 1'b0;
                        if (GAP_NONE) begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= GAP_LD;
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt  <= r_cnt - CNT_ONE;
                        r_done <= (r_cnt == CNT_ONE);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign d         = r_d;
    assign s         = r_s;
    assign En        = r_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb/tb_demux_route_ctrl.sv - self-checking bench for demux_route_ctrl (HOLD=4/GAP=1 and HOLD=1/GAP=0 builds)
module tb_demux_route_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      vld, rdy, dat, abt, dd, en, bsy, dn, abd;
    logic [1:0][1:0] dst, ss;

    int n_vec = 0;
    int n_err = 0;

    demux_route_ctrl #(.HOLD_CYC(4), .GAP_CYC(1), .CW(8)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_dest(dst[0]), .req_data(dat[0]), .abort(abt[0]), .d(dd[0]),
        .s(ss[0]), .En(en[0]), .busy(bsy[0]), .done(dn[0]), .aborted(abd[0])
    );

    demux_route_ctrl #(.HOLD_CYC(1), .GAP_CYC(0), .CW(8)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_dest(dst[1]), .req_data(dat[1]), .abort(abt[1]), .d(dd[1]),
        .s(ss[1]), .En(en[1]), .busy(bsy[1]), .done(dn[1]), .aborted(abd[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from an IDLE cycle with ready high; a = cycle offset of the
    // abort pulse (1 = SETUP, 2..H = DRIVE), 0 = no abort. Returns in the
    // first IDLE cycle afterwards so the next call is back-to-back.
    task automatic txn(input int sel, input logic [1:0] dest, input logic data, input int a);
        int h, g, r, gs;
        logic e_en, e_done, e_ab;
        h  = (sel == 1) ? 1 : 4;
        g  = (sel == 1) ? 0 : 1;
        r  = (a == 0) ? h + 2 + g : a + ((g < 1) ? 1 : g) + 1;
        gs = (a == 0) ? h + 2 : a + 1;
        chk($sformatf("ready_pre%0d", sel), rdy[sel], 1);
        vld[sel] = 1'b1;
        dst[sel] = dest;
        dat[sel] = data;
        abt[sel] = (a == 1);
        for (int k = 1; k <= r; k++) begin
            tick();
            e_en   = (a == 0) ? (k >= 2 && k <= h + 1) : (k >= 2 && k <= a);
            e_done = (a == 0) && (k == h + 1);
            e_ab   = (a != 0) && (k == a + 1);
            chk($sformatf("en%0d_k%0d", sel, k), en[sel], e_en);
            chk($sformatf("done%0d_k%0d", sel, k), dn[sel], e_done);
            chk($sformatf("aborted%0d_k%0d", sel, k), abd[sel], e_ab);
            chk($sformatf("busy%0d_k%0d", sel, k), bsy[sel], (k < r));
            chk($sformatf("ready%0d_k%0d", sel, k), rdy[sel], (k >= r));
            chk($sformatf("s%0d_k%0d", sel, k), ss[sel], dest);
            chk($sformatf("d%0d_k%0d", sel, k), dd[sel], data);
            vld[sel] = (k < r) ? 1'($urandom) : 1'b0;
            dst[sel] = 2'($urandom);
            dat[sel] = 1'($urandom);
            abt[sel] = (k == a) || (k >= gs && k < r && 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        vld = '0; abt = '0; dat = '0; dst = '0;
        tick();
        tick();
        chk("rst_en", en[0], 0);
        chk("rst_s", ss[0], 0);
        chk("rst_d", dd[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_aborted", abd[0], 0);
        chk("rst_ready0", rdy[0], 0);
        chk("rst_ready1", rdy[1], 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready0", rdy[0], 1);
        chk("post_rst_ready1", rdy[1], 1);

        txn(0, 2'b00, 1'b1, 0);
        txn(0, 2'b01, 1'b0, 0);
        txn(0, 2'b10, 1'b1, 0);
        txn(0, 2'b11, 1'b0, 0);
        txn(0, 2'b10, 1'b1, 3);
        txn(0, 2'b11, 1'b1, 1);

        // reset in the 3rd DRIVE cycle
        vld[0] = 1'b1; dst[0] = 2'b01; dat[0] = 1'b1; abt[0] = 1'b0;
        tick();
        vld[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_en_before_rst", en[0], 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_en", en[0], 0);
        chk("mid_rst_s", ss[0], 0);
        chk("mid_rst_d", dd[0], 0);
        chk("mid_rst_busy", bsy[0], 0);
        chk("mid_rst_done", dn[0], 0);
        chk("mid_rst_aborted", abd[0], 0);
        chk("mid_rst_ready", rdy[0], 0);
        rst = 1'b0;
        tick();
        chk("mid_post_ready", rdy[0], 1);

        repeat (12) txn(0, 2'($urandom), 1'($urandom), int'($urandom_range(0, 4)));

        txn(1, 2'b10, 1'b1, 0);
        txn(1, 2'b11, 1'b0, 0);
        txn(1, 2'b01, 1'b1, 1);
        txn(1, 2'b00, 1'b1, 0);
        repeat (6) txn(1, 2'($urandom), 1'($urandom), int'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
